instr_fetch_unit: RTL and testbench

Upstream fetch stage for the MIPS single-cycle datapath. Holds the PC and requests instructions from instruction memory over a req/ack handshake. Latches each returned word into an instruction register and presents the opcode field to the main controller with a valid flag. Once the downstream stage signals completion, it advances the PC sequentially or to the branch target.

---
 rtl/instr_fetch_unit.sv | 86 ++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle MIPS datapath. It holds the PC, fetches a word over a
// req/ack handshake, and presents it in an instruction register until the downstream stage consumes it.
module instr_fetch_unit #(
    parameter int                 IMEM_AW  = 32,
    parameter logic [IMEM_AW-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [IMEM_AW-1:0] pc,
    output logic [IMEM_AW-1:0] pc_plus4,
    output logic [31:0]        ir,
    output logic [5:0]         op,
    output logic               instr_valid,
    input  logic               ex_done,
    input  logic               branch,
    input  logic               zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [IMEM_AW-1:0] RESET_PC_ALIGNED = {RESET_PC[IMEM_AW-1:2], 2'b00};

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [IMEM_AW-1:0] branch_off;
    logic [IMEM_AW-1:0] next_pc;

    // Word offset from the immediate: sign-extend, then scale to bytes.
    assign branch_off = {{(IMEM_AW-18){ir_q[15]}}, ir_q[15:0], 2'b00};
    assign pc_plus4   = pc_q + IMEM_AW'(4);
    assign next_pc    = (branch && zero) ? (pc_plus4 + branch_off) : pc_plus4;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC_ALIGNED;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                // ex_done wins over a stray ack here; the ack is simply not looked at.
                if (ex_done) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign instr_valid = (state_q == VALID);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign op          = ir_q[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus randomized fetch/execute traffic
// compared against a PC/IR reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        rst, imem_ack, ex_done, branch, zero;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, pc, pc_plus4, ir;
    logic [5:0]  op;

    // Wrap-around DUT (unaligned reset PC at the top of the address space)
    logic        rst_w, ack_w, ex_done_w, branch_w, zero_w;
    logic [31:0] rdata_w;
    logic        req_w, valid_w;
    logic [31:0] addr_w, pc_w, pc4_w, ir_w;
    logic [5:0]  op_w;

    instr_fetch_unit #(.IMEM_AW(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4),
        .ir(ir), .op(op), .instr_valid(instr_valid), .ex_done(ex_done),
        .branch(branch), .zero(zero)
    );

    instr_fetch_unit #(.IMEM_AW(32), .RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst(rst_w), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_rdata(rdata_w), .pc(pc_w), .pc_plus4(pc4_w),
        .ir(ir_w), .op(op_w), .instr_valid(valid_w), .ex_done(ex_done_w),
        .branch(branch_w), .zero(zero_w)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural PC and IR only.
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next PC from the branch rule, written as plain signed arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic br, input logic zr);
        int off;
        off = $signed(word[15:0]);
        if (br && zr) return cur + 32'(4 + off * 4);
        return cur + 32'd4;
    endfunction

    task automatic reset_main();
        rst = 1'b1; imem_ack = 1'b0; ex_done = 1'b0; branch = 1'b0; zero = 1'b0; imem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        m_pc = 32'h0; m_ir = 32'h0;
    endtask

    // One instruction starting in REQ: wait cycles, ack, linger in VALID, then ex_done.
    task automatic do_instr(input int waits, input logic [31:0] word, input logic br,
                            input logic zr, input int hold);
        for (int w = 0; w < waits; w++) begin
            imem_ack = 1'b0; ex_done = 1'($urandom_range(0, 1));
            branch = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
            tick();
            check("wait_req", imem_req, 1'b1);
            check("wait_addr", imem_addr, m_pc);
            check("wait_valid", instr_valid, 1'b0);
            check("wait_pc", pc, m_pc);
        end
        imem_ack = 1'b1; imem_rdata = word; ex_done = 1'($urandom_range(0, 1));
        tick();
        imem_ack = 1'b0; ex_done = 1'b0;
        m_ir = word;
        check("ack_valid", instr_valid, 1'b1);
        check("ack_req", imem_req, 1'b0);
        check("ack_ir", ir, m_ir);
        check("ack_op", op, m_ir[31:26]);
        for (int h = 0; h < hold; h++) begin
            imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom();
            branch = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
            tick();
            check("hold_valid", instr_valid, 1'b1);
            check("hold_ir", ir, m_ir);
            check("hold_pc", pc, m_pc);
        end
        ex_done = 1'b1; branch = br; zero = zr;
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom();
        tick();
        ex_done = 1'b0; imem_ack = 1'b0; branch = 1'b0; zero = 1'b0;
        m_pc = model_next(m_pc, m_ir, br, zr);
        check("exec_pc", pc, m_pc);
        check("exec_addr", imem_addr, m_pc);
        check("exec_req", imem_req, 1'b1);
        check("exec_ir_kept", ir, m_ir);
        check("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
    endtask

    initial begin
        rst_w = 1'b1; ack_w = 1'b0; ex_done_w = 1'b0; branch_w = 1'b0; zero_w = 1'b0; rdata_w = '0;

        // Reset, then IDLE for one cycle, then REQ at address 0.
        reset_main();
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_op", op, 6'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        tick();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);

        // Zero-wait fetch of a lw, then sequential advance.
        do_instr(0, 32'h8C22_0004, 1'b0, 1'b0, 0);
        check("lw_op", op, 6'b100011);
        check("lw_pc", pc, 32'h4);

        // Three wait states with stray ex_done pulses, then walk pc up to 0x10.
        do_instr(3, 32'h0000_0000, 1'b0, 1'b0, 2);
        check("wait_done_pc", pc, 32'h8);
        do_instr(1, 32'h0123_4567, 1'b0, 1'b0, 0);
        do_instr(0, 32'h0000_0020, 1'b1, 1'b0, 1);
        check("at_0x10", pc, 32'h10);

        // Branch cases from 0x10.
        do_instr(0, 32'h1000_FFFF, 1'b1, 1'b1, 0);
        check("beq_back", pc, 32'h10);
        do_instr(1, 32'h1000_0003, 1'b1, 1'b1, 0);
        check("beq_fwd", pc, 32'h20);
        do_instr(0, 32'h1000_FFFF, 1'b1, 1'b0, 0);
        check("beq_not_taken", pc, 32'h24);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] word;
            word = $urandom();
            if ($urandom_range(0, 1) == 1) word[31:26] = 6'b000100;
            do_instr(int'($urandom_range(0, 3)), word, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        // Reset in the second wait cycle at pc 0x8, with an ack arriving alongside.
        reset_main();
        tick();
        do_instr(0, 32'hABCD_0001, 1'b0, 1'b0, 0);
        do_instr(0, 32'h8C22_0004, 1'b0, 1'b0, 0);
        check("pre_abort_pc", pc, 32'h8);
        imem_ack = 1'b0;
        tick();
        check("pre_abort_req", imem_req, 1'b1);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        check("abort_pc", pc, 32'h0);
        check("abort_req", imem_req, 1'b0);
        check("abort_valid", instr_valid, 1'b0);
        check("abort_ir", ir, 32'h0);
        tick();
        imem_ack = 1'b0;
        check("idle_ack_ir", ir, 32'h0);
        check("idle_ack_valid", instr_valid, 1'b0);
        check("idle_ack_req", imem_req, 1'b1);

        // Wrap-around instance: low PC bits forced to 00, pc+4 wraps to 0.
        tick();
        rst_w = 1'b0;
        check("wrap_rst_pc", pc_w, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4_w, 32'h0);
        tick();
        check("wrap_addr", addr_w, 32'hFFFF_FFFC);
        ack_w = 1'b1; rdata_w = 32'h2008_0001;
        tick();
        ack_w = 1'b0;
        check("wrap_valid", valid_w, 1'b1);
        check("wrap_op", op_w, 6'b001000);
        ex_done_w = 1'b1;
        tick();
        ex_done_w = 1'b0;
        check("wrap_pc", pc_w, 32'h0);
        check("wrap_addr0", addr_w, 32'h0);
        check("wrap_req", req_w, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
